// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-file write-back entry layout.
package cpu_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first match of one read index against the pending write entries.
// Entries arrive age-ordered: index 0 is the oldest, DEPTH-1 the youngest.
module wb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] rd_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]            idx_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);
  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_i[i] && (rd_i[i] == idx_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[i];
      end
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue between result producers and the register file write port.
// Define WB_FWD_EN to build forwarding of pending writes to the two read ports.
module regfile_wb_queue #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       wb_stall,
  output logic                       write_en,
  output logic [ADDR_W-1:0]          wreg,
  output logic [DATA_W-1:0]          writedata,
  input  logic [ADDR_W-1:0]          rega,
  input  logic [ADDR_W-1:0]          regb,
  output logic                       fwd_a_hit,
  output logic                       fwd_b_hit,
  output logic [DATA_W-1:0]          fwd_a_data,
  output logic [DATA_W-1:0]          fwd_b_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty, push, pop;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign push      = in_valid & in_ready;
  assign write_en  = not_empty & ~wb_stall;
  assign pop       = write_en;
  assign wreg      = not_empty ? mem_q[rd_ptr_q].rd   : '0;
  assign writedata = not_empty ? mem_q[rd_ptr_q].data : '0;
  assign count     = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; count_q gates every use of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: in_reg, data: in_data};
  end

`ifdef WB_FWD_EN
  logic [DEPTH-1:0]             age_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] age_rd;
  logic [DEPTH-1:0][DATA_W-1:0] age_data;
  logic [PTR_W-1:0]             slot;
  logic [1:0][ADDR_W-1:0]       port_idx;
  logic [1:0]                   port_hit;
  logic [1:0][DATA_W-1:0]       port_data;

  // Re-order storage oldest-to-youngest starting at the head.
  always_comb begin
    slot     = '0;
    age_vld  = '0;
    age_rd   = '0;
    age_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot        = rd_ptr_q + PTR_W'(i);
      age_vld[i]  = (CNT_W'(i) < count_q);
      age_rd[i]   = mem_q[slot].rd;
      age_data[i] = mem_q[slot].data;
    end
  end

  assign port_idx = {regb, rega};

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match (
      .vld_i  (age_vld),
      .rd_i   (age_rd),
      .data_i (age_data),
      .idx_i  (port_idx[p]),
      .hit_o  (port_hit[p]),
      .data_o (port_data[p])
    );
  end

  assign fwd_a_hit  = port_hit[0];
  assign fwd_b_hit  = port_hit[1];
  assign fwd_a_data = port_data[0];
  assign fwd_b_data = port_data[1];
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^{rega, regb};
  assign fwd_a_hit  = 1'b0;
  assign fwd_b_hit  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue; forwarding expectations follow WB_FWD_EN.
module tb_regfile_wb_queue;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wb_stall;
  logic              write_en;
  logic [ADDR_W-1:0] wreg;
  logic [DATA_W-1:0] writedata;
  logic [ADDR_W-1:0] rega, regb;
  logic              fwd_a_hit, fwd_b_hit;
  logic [DATA_W-1:0] fwd_a_data, fwd_b_data;
  logic [2:0]        count;

  int checks   = 0;
  int failures = 0;

  regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data), .in_ready(in_ready),
    .wb_stall(wb_stall), .write_en(write_en), .wreg(wreg), .writedata(writedata),
    .rega(rega), .regb(regb),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_reg   = r;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_stall = 1'b0; rega = '0; regb = '0;
    offer(1'b0, '0, '0);
    #2;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL rst_write_en got=%b exp=0", write_en); end
    checks++; if ({wreg, writedata} !== '0) begin failures++; $display("FAIL rst_wport got=%h/%h exp=0/0", wreg, writedata); end
    checks++; if ({fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data} !== '0) begin failures++; $display("FAIL rst_fwd got=%b%b %h %h exp=0", fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    offer(1'b1, 3'd1, 16'h0001);
    #1;
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL single_no_passthru got=%b exp=0", write_en); end
    tick();
    offer(1'b0, '0, '0);
    #1;
    checks++; if ({write_en, wreg, writedata} !== {1'b1, 3'd1, 16'h0001}) begin failures++; $display("FAIL single_write got=%b/%0d/%h exp=1/1/0001", write_en, wreg, writedata); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
    tick();
    checks++; if ({count, write_en, wreg, writedata} !== '0) begin failures++; $display("FAIL single_empty got=%0d/%b/%0d/%h exp=0", count, write_en, wreg, writedata); end
  endtask

  task automatic test_full_stall();
    logic [ADDR_W-1:0] er [4];
    logic [DATA_W-1:0] ed [4];
    er = '{3'd2, 3'd3, 3'd4, 3'd5};
    ed = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, er[k], ed[k]);
      tick();
    end
    offer(1'b1, 3'd6, 16'h6666);
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    tick();
    offer(1'b0, '0, '0);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_drop_count got=%0d exp=4", count); end
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({write_en, wreg, writedata, count} !== {1'b1, er[k], ed[k], 3'(4 - k)}) begin failures++; $display("FAIL drain_%0d got=%b/%0d/%h/%0d exp=1/%0d/%h/%0d", k, write_en, wreg, writedata, count, er[k], ed[k], 4 - k); end
      tick();
    end
    checks++; if ({count, write_en} !== '0) begin failures++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, write_en); end
  endtask

  task automatic test_forwarding();
    wb_stall = 1'b1;
    rega = 3'd4; regb = 3'd0;
    offer(1'b1, 3'd4, 16'h1111);
    tick();
    offer(1'b1, 3'd4, 16'h2222);
    #1;
    checks++; if ({fwd_a_hit, fwd_a_data} !== {FWD, (FWD ? 16'h1111 : 16'h0000)}) begin failures++; $display("FAIL fwd_not_yet got=%b/%h exp=%b/%h", fwd_a_hit, fwd_a_data, FWD, FWD ? 16'h1111 : 16'h0000); end
    tick();
    offer(1'b0, '0, '0);
    #1;
    checks++; if ({fwd_a_hit, fwd_a_data} !== {FWD, (FWD ? 16'h2222 : 16'h0000)}) begin failures++; $display("FAIL fwd_youngest got=%b/%h exp=%b/%h", fwd_a_hit, fwd_a_data, FWD, FWD ? 16'h2222 : 16'h0000); end
    checks++; if ({fwd_b_hit, fwd_b_data} !== '0) begin failures++; $display("FAIL fwd_nomatch got=%b/%h exp=0/0000", fwd_b_hit, fwd_b_data); end
    wb_stall = 1'b0;
    #1;
    checks++; if ({write_en, wreg, writedata} !== {1'b1, 3'd4, 16'h1111}) begin failures++; $display("FAIL fwd_drain0 got=%b/%0d/%h exp=1/4/1111", write_en, wreg, writedata); end
    checks++; if ({fwd_a_hit, fwd_a_data} !== {FWD, (FWD ? 16'h2222 : 16'h0000)}) begin failures++; $display("FAIL fwd_head_draining got=%b/%h exp=%b/%h", fwd_a_hit, fwd_a_data, FWD, FWD ? 16'h2222 : 16'h0000); end
    tick();
    checks++; if ({write_en, wreg, writedata} !== {1'b1, 3'd4, 16'h2222}) begin failures++; $display("FAIL fwd_drain1 got=%b/%0d/%h exp=1/4/2222", write_en, wreg, writedata); end
    checks++; if ({fwd_a_hit, fwd_a_data} !== {FWD, (FWD ? 16'h2222 : 16'h0000)}) begin failures++; $display("FAIL fwd_head_only got=%b/%h exp=%b/%h", fwd_a_hit, fwd_a_data, FWD, FWD ? 16'h2222 : 16'h0000); end
    tick();
    checks++; if ({count, fwd_a_hit, fwd_a_data} !== '0) begin failures++; $display("FAIL fwd_empty got=%0d/%b/%h exp=0", count, fwd_a_hit, fwd_a_data); end
  endtask

  task automatic test_full_push_pop_wrap();
    logic [ADDR_W-1:0] er [4];
    logic [DATA_W-1:0] ed [4];
    er = '{3'd0, 3'd1, 3'd2, 3'd3};
    ed = '{16'h0A00, 16'h0B11, 16'h0C22, 16'h0D33};
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, er[k], ed[k]);
      tick();
    end
    regb = 3'd0;
    offer(1'b1, 3'd7, 16'h7777);
    wb_stall = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fullpop_in_ready got=%b exp=0", in_ready); end
    checks++; if ({write_en, wreg, writedata} !== {1'b1, 3'd0, 16'h0A00}) begin failures++; $display("FAIL fullpop_head_r0 got=%b/%0d/%h exp=1/0/0a00", write_en, wreg, writedata); end
    checks++; if ({fwd_b_hit, fwd_b_data} !== {FWD, (FWD ? 16'h0A00 : 16'h0000)}) begin failures++; $display("FAIL fwd_r0 got=%b/%h exp=%b/%h", fwd_b_hit, fwd_b_data, FWD, FWD ? 16'h0A00 : 16'h0000); end
    tick();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL fullpop_count got=%0d exp=3", count); end
    offer(1'b1, 3'd5, 16'h5555);
    #1;
    checks++; if ({in_ready, write_en, wreg} !== {1'b1, 1'b1, 3'd1}) begin failures++; $display("FAIL pushpop_pre got=%b/%b/%0d exp=1/1/1", in_ready, write_en, wreg); end
    tick();
    offer(1'b0, '0, '0);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL pushpop_count got=%0d exp=3", count); end
    er = '{3'd2, 3'd3, 3'd5, 3'd0};
    ed = '{16'h0C22, 16'h0D33, 16'h5555, 16'h0000};
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({write_en, wreg, writedata} !== {1'b1, er[k], ed[k]}) begin failures++; $display("FAIL wrap_drain_%0d got=%b/%0d/%h exp=1/%0d/%h", k, write_en, wreg, writedata, er[k], ed[k]); end
      tick();
    end
    checks++; if ({count, write_en} !== '0) begin failures++; $display("FAIL wrap_empty got=%0d/%b exp=0/0", count, write_en); end
  endtask

  task automatic test_async_reset();
    wb_stall = 1'b1;
    rega = 3'd6;
    offer(1'b1, 3'd6, 16'h6006);
    tick();
    offer(1'b1, 3'd1, 16'h1001);
    tick();
    offer(1'b0, '0, '0);
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL arst_pre_count got=%0d exp=2", count); end
    wb_stall = 1'b0;
    #1;
    checks++; if ({write_en, wreg} !== {1'b1, 3'd6}) begin failures++; $display("FAIL arst_pre_we got=%b/%0d exp=1/6", write_en, wreg); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({write_en, count, wreg, writedata} !== '0) begin failures++; $display("FAIL arst_immediate got=%b/%0d/%0d/%h exp=0", write_en, count, wreg, writedata); end
    checks++; if ({in_ready, fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data} !== {1'b1, 34'd0}) begin failures++; $display("FAIL arst_ready_fwd got=%b/%b/%h exp=1/0/0000", in_ready, fwd_a_hit, fwd_a_data); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if ({write_en, count, fwd_a_hit} !== '0) begin failures++; $display("FAIL arst_after_%0d got=%b/%0d/%b exp=0/0/0", k, write_en, count, fwd_a_hit); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_full_stall();
    test_forwarding();
    test_full_push_pop_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
